// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. The serial line passes through a 2-FF
//   synchroniser. A falling edge on the synchronised line starts a frame. Each
//   bit is decided by a 3-sample majority vote around mid-period, and data is
//   shifted in LSB first. Each good word goes into a one-entry valid/ready
//   holding register. Framing errors, overrun errors and (optionally) parity
//   errors are reported as 1-cycle pulses.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 8)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY_ODD    1 = odd parity, 0 = even parity (parity build only)
//
// Build option
//   UART_RX_PARITY_EN  when defined, a parity bit follows the data bits and is
//                      checked. When undefined, the frame is start + data +
//                      stop and parity_err is tied low.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           asynchronous serial line, idles high
//   rx_data      received word, stable while rx_valid is high
//   rx_valid     holding register full
//   rx_ready     consumer takes the word when rx_valid & rx_ready
//   frame_err    1-cycle pulse, stop bit voted 0
//   overrun_err  1-cycle pulse, new word dropped because holding reg was full
//   parity_err   1-cycle pulse, parity mismatch (coincides with commit)
//   busy         receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_param: illegal parameter value");
  end

  localparam int TW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] T_SAMP0 = TW'(MID - 1);
  localparam logic [TW-1:0] T_SAMP1 = TW'(MID);
  localparam logic [TW-1:0] T_VOTE  = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);

  // state    | meaning
  // S_IDLE   | line idle, waiting for a falling edge
  // S_START  | qualifying the start bit at mid-period
  // S_DATA   | sampling data bits, LSB first
  // S_PARITY | sampling the parity bit (parity build only)
  // S_STOP   | sampling the stop bit, commit or flag framing error
  // S_BREAK  | stop bit was 0, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [1:0]             samp_q, samp_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;

  logic rx_s;
  logic vote;
  logic at_vote;

  assign rx_s    = sync2_q;
  // Majority of the two stored samples and the live third sample.
  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign at_vote = (timer_q == T_VOTE);

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = 1'(PARITY_ODD);
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
`endif

  always_comb begin
    sync1_d       = rx;
    sync2_d       = sync1_q;
    rx_prev_d     = rx_s;
    state_d       = state_q;
    timer_d       = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;
    samp_d        = samp_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    rx_data_d     = rx_data_q;
    // Handshake empties the holding register; a commit below may refill it.
    rx_valid_d    = rx_valid_q & ~rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif

    if (timer_q == T_SAMP0) samp_d[0] = rx_s;
    if (timer_q == T_SAMP1) samp_d[1] = rx_s;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (rx_prev_q & ~rx_s) state_d = S_START;
      end
      S_START: begin
        if (at_vote) begin
          if (vote) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end
        end
      end
      S_DATA: begin
        if (at_vote) begin
          shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_vote) begin
          par_bad_d = vote ^ (^shreg_q) ^ PAR_ODD_BIT;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (at_vote) begin
          if (vote) begin
            // Leave on the vote cycle so a following start edge is not missed.
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            if (rx_valid_q & ~rx_ready) begin
              overrun_err_d = 1'b1;
            end else begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_prev_q     <= 1'b1;
      timer_q       <= '0;
      samp_q        <= 2'b11;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rx_prev_q     <= rx_prev_d;
      timer_q       <= timer_d;
      samp_q        <= samp_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam bit P_ODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] got_q[$];
  int n_frame = 0;
  int n_overrun = 0;
  int n_parity = 0;
  int n_valid_cyc = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(DB),
    .PARITY_ODD(int'(P_ODD))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun_err(overrun_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  // Passive monitor: records delivered words and counts error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (rx_valid)    n_valid_cyc <= n_valid_cyc + 1;
      if (frame_err)   n_frame     <= n_frame + 1;
      if (overrun_err) n_overrun   <= n_overrun + 1;
      if (parity_err)  n_parity    <= n_parity + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    tick(n);
  endtask

  // Serial frame: start, data LSB first, optional parity, stop.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_ok);
    drive(1'b0, CPB);
    for (int i = 0; i < DB; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ P_ODD ^ ~par_ok, CPB);
`else
    if (!par_ok) $display("note: parity request ignored in this build");
`endif
    drive(stop_v, CPB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    checks++; if (rx_data !== '0)      begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    int base = got_q.size();
    int f0 = n_frame, o0 = n_overrun, p0 = n_parity, v0 = n_valid_cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    tick(4);
    checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL a5_count: got %0d want %0d", got_q.size() - base, 1); end
    else begin
      checks++; if (got_q[base] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", got_q[base]); end
    end
    checks++; if (n_valid_cyc - v0 !== 1) begin errors++; $display("FAIL a5_valid_cycles: got %0d want 1", n_valid_cyc - v0); end
    checks++; if ((n_frame - f0) + (n_overrun - o0) + (n_parity - p0) !== 0)
      begin errors++; $display("FAIL a5_err_pulses: got %0d want 0", (n_frame - f0) + (n_overrun - o0) + (n_parity - p0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int base = got_q.size();
    int f0 = n_frame;
    drive(1'b0, 3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_set: got %b want 1", busy); end
    drive(1'b1, 2 * CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b want 0", busy); end
    checks++; if (got_q.size() !== base) begin errors++; $display("FAIL glitch_delivery: got %0d want 0", got_q.size() - base); end
    checks++; if (n_frame !== f0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", n_frame - f0); end
  endtask

  task automatic test_break();
    int base = got_q.size();
    int f0 = n_frame;
    send_frame(8'h3C, 1'b0, 1'b1);
    drive(1'b0, 40 * CPB);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held: got %b want 1", busy); end
    drive(1'b1, 2 * CPB);
    checks++; if (n_frame - f0 !== 1) begin errors++; $display("FAIL break_frame_err_count: got %0d want 1", n_frame - f0); end
    checks++; if (got_q.size() !== base) begin errors++; $display("FAIL break_delivery: got %0d want 0", got_q.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_clear: got %b want 0", busy); end
    send_frame(8'h81, 1'b1, 1'b1);
    tick(4);
    checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL recover_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'h81) begin errors++; $display("FAIL recover_data: got %h want 81", got_q[base]); end
    end
  endtask

  task automatic test_overrun();
    int base = got_q.size();
    int o0 = n_overrun;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    tick(4);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h want 11", rx_data); end
    checks++; if (n_overrun - o0 !== 1) begin errors++; $display("FAIL ovr_pulse_count: got %0d want 1", n_overrun - o0); end
    rx_ready = 1'b1;
    tick(1);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_keep: got %h want 11", rx_data); end
    checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL ovr_accept_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'h11) begin errors++; $display("FAIL ovr_accept_data: got %h want 11", got_q[base]); end
    end
  endtask

  task automatic test_spike();
    int base = got_q.size();
    int f0 = n_frame;
    drive(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      if (i == 3) begin
        drive(1'b1, CPB / 2 + 1);
        drive(1'b0, 1);
        drive(1'b1, CPB / 2 - 2);
      end else begin
        drive(1'b1, CPB);
      end
    end
`ifdef UART_RX_PARITY_EN
    drive(P_ODD, CPB);
`endif
    drive(1'b1, CPB);
    tick(4);
    checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL spike_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'hFF) begin errors++; $display("FAIL spike_data: got %h want ff", got_q[base]); end
    end
    checks++; if (n_frame !== f0) begin errors++; $display("FAIL spike_frame_err: got %0d want 0", n_frame - f0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [DB-1:0] d = 8'h5A;
    int base = got_q.size();
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(d[i], CPB);
    drive(d[4], CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== '0)    begin errors++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * CPB);
    checks++; if (got_q.size() !== base) begin errors++; $display("FAIL rstmid_delivery: got %0d want 0", got_q.size() - base); end
    send_frame(d, 1'b1, 1'b1);
    tick(4);
    checks++; if (got_q.size() !== base + 1) begin errors++; $display("FAIL rstmid_next_count: got %0d want 1", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data: got %h want 5a", got_q[base]); end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [DB-1:0] exp_q[$];
    int base = got_q.size();
    int f0 = n_frame, o0 = n_overrun, p0 = n_parity;
    for (int n = 0; n < 20; n++) begin
      logic [DB-1:0] d;
      int gap;
      d = DB'($urandom_range(0, 255));
      gap = (n % 4 == 0) ? 0 : $urandom_range(0, 6);
      exp_q.push_back(d);
      send_frame(d, 1'b1, 1'b1);
      if (gap > 0) drive(1'b1, gap);
    end
    tick(4);
    checks++; if (got_q.size() - base !== exp_q.size())
      begin errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[base + i] !== exp_q[i])
          begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[base + i], exp_q[i]); end
      end
    end
    checks++; if ((n_frame - f0) + (n_overrun - o0) + (n_parity - p0) !== 0)
      begin errors++; $display("FAIL rand_err_pulses: got %0d want 0", (n_frame - f0) + (n_overrun - o0) + (n_parity - p0)); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int base = got_q.size();
    int p0 = n_parity;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(4);
    checks++; if (n_parity !== p0) begin errors++; $display("FAIL par_clean_pulse: got %0d want 0", n_parity - p0); end
    send_frame(8'h07, 1'b1, 1'b0);
    tick(4);
    checks++; if (n_parity - p0 !== 1) begin errors++; $display("FAIL par_bad_pulse: got %0d want 1", n_parity - p0); end
    checks++; if (got_q.size() !== base + 2) begin errors++; $display("FAIL par_count: got %0d want 2", got_q.size() - base); end
    else begin
      checks++; if (got_q[base] !== 8'h07)     begin errors++; $display("FAIL par_clean_data: got %h want 07", got_q[base]); end
      checks++; if (got_q[base + 1] !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h want 07", got_q[base + 1]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_break();
    test_overrun();
    test_spike();
    test_reset_mid_frame();
    test_back_to_back_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
